// File: rtl/tpu_pkg.sv
// Shared TPU definitions: default buffer geometry and the writeback FSM state encoding.
package tpu_pkg;

    localparam int ROW_LEN_DEF = 8;
    localparam int ADDR_W_DEF  = 16;
    localparam int ELEM_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_row_packer.sv
// Row assembly register: one slot per element, written by index, cleared as a whole,
// presented as a packed row with element 0 in the least significant bits.
module row_packer #(
    parameter  int ROW_LEN = 8,
    parameter  int ELEM_W  = 32,
    localparam int IDX_W   = $clog2(ROW_LEN)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [ELEM_W-1:0]         wr_data,
    output logic [ROW_LEN*ELEM_W-1:0] row
);

    logic [ELEM_W-1:0] slot_q [ROW_LEN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROW_LEN; i++) slot_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < ROW_LEN; i++) slot_q[i] <= '0;
        end else if (wr_en) begin
            slot_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        row = '0;
        for (int i = 0; i < ROW_LEN; i++) row[i*ELEM_W +: ELEM_W] = slot_q[i];
    end

endmodule

// File: rtl/writeback_unit.sv
// Collects activation elements into buffer rows and writes each full row to the buffer.
//   state      | meaning
//   ST_IDLE    | waiting for start; element input ignored
//   ST_COLLECT | accepting one element per in_valid cycle into the row packer
//   ST_WRITE   | row write request held until mem_ack
//   ST_DONE    | one-cycle done pulse, then back to idle
module writeback_unit
    import tpu_pkg::*;
#(
    parameter int ROW_LEN = ROW_LEN_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [7:0]                num_rows,
    input  logic                      in_valid,
    input  logic signed [31:0]        in,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [ROW_LEN*32-1:0]     mem_wdata,
    input  logic                      mem_ack,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int IDX_W = $clog2(ROW_LEN);

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        rows_q;
    logic [7:0]        row_cnt;
    logic [IDX_W-1:0]  elem_cnt;
    logic              overrun_q;
    logic              start_ok, accept, row_full, last_row, drop;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign accept   = (state_q == ST_COLLECT) && in_valid;
    assign row_full = (elem_cnt == IDX_W'(ROW_LEN - 1));
    assign last_row = (row_cnt == rows_q - 8'd1);
    assign drop     = in_valid && ((state_q == ST_WRITE) || (state_q == ST_DONE));

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = (num_rows == 8'd0) ? ST_DONE : ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (accept && row_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (mem_ack) state_d = last_row ? ST_DONE : ST_COLLECT;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            row_cnt   <= '0;
            elem_cnt  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q    <= base_addr;
                rows_q    <= num_rows;
                row_cnt   <= '0;
                elem_cnt  <= '0;
                overrun_q <= 1'b0;
            end else begin
                if (accept) elem_cnt <= row_full ? '0 : elem_cnt + 1'b1;
                if ((state_q == ST_WRITE) && mem_ack && !last_row) row_cnt <= row_cnt + 8'd1;
                if (drop) overrun_q <= 1'b1;
            end
        end
    end

    // Row address wraps naturally at the buffer address width.
    assign mem_addr = base_q + ADDR_W'(row_cnt);
    assign overrun  = overrun_q;

    row_packer #(
        .ROW_LEN (ROW_LEN),
        .ELEM_W  (ELEM_W)
    ) u_row_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_ok),
        .wr_en   (accept),
        .wr_idx  (elem_cnt),
        .wr_data (in),
        .row     (mem_wdata)
    );

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit: rows are predicted by chunking the driven element stream.
module tb_writeback_unit;

    localparam int ROW_LEN = 8;
    localparam int ADDR_W  = 16;
    localparam int RW      = ROW_LEN * 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [7:0]               num_rows;
    logic                     in_valid;
    logic signed [31:0]       in;
    logic                     in_ready;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [RW-1:0]            mem_wdata;
    logic                     mem_ack;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    int   n_cmp   = 0;
    int   n_err   = 0;
    int   wr_seen = 0;
    int   wr_exp  = 0;
    logic exp_ov  = 1'b0;

    writeback_unit #(.ROW_LEN(ROW_LEN), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .in_valid  (in_valid),
        .in        (in),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset && mem_we && mem_ack) wr_seen++;

    task automatic check(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in       = $urandom;
            mem_ack  = 1'($urandom_range(0, 1));
            check("idle_busy", busy, 0);
            check("idle_we", mem_we, 0);
            check("idle_rdy", in_ready, 0);
            check("idle_ovr", overrun, exp_ov);
            step();
        end
        in_valid = 1'b0;
        mem_ack  = 1'b0;
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] b, input int n, input int max_gap,
                           input int dmin, input int dmax, input bit inject, input bit seq);
        logic [31:0]       row [ROW_LEN];
        logic [RW-1:0]     exp_w;
        logic [ADDR_W-1:0] ea;
        int                gap;
        int                d;
        start     = 1'b1;
        base_addr = b;
        num_rows  = 8'(n);
        step();
        start  = 1'b0;
        exp_ov = 1'b0;
        check("ovr_clr", overrun, 0);
        if (n == 0) begin
            check("done_zero", done, 1);
            check("we_zero", mem_we, 0);
            step();
            check("done_zero_end", done, 0);
            check("busy_zero_end", busy, 0);
            check("we_zero_end", mem_we, 0);
            return;
        end
        for (int r = 0; r < n; r++) begin
            for (int e = 0; e < ROW_LEN; e++) begin
                gap = $urandom_range(0, max_gap);
                for (int g = 0; g < gap; g++) begin
                    in_valid  = 1'b0;
                    mem_ack   = 1'($urandom_range(0, 1));
                    start     = 1'($urandom_range(0, 1));
                    base_addr = 16'($urandom);
                    num_rows  = 8'($urandom);
                    check("rdy_gap", in_ready, 1);
                    check("we_gap", mem_we, 0);
                    step();
                end
                mem_ack  = 1'b0;
                start    = 1'b0;
                row[e]   = seq ? 32'(r * ROW_LEN + e + 1) : $urandom;
                in       = row[e];
                in_valid = 1'b1;
                check("rdy", in_ready, 1);
                check("busy", busy, 1);
                step();
                in_valid = 1'b0;
            end
            exp_w = '0;
            for (int e = 0; e < ROW_LEN; e++) exp_w[e*32 +: 32] = row[e];
            ea = b + ADDR_W'(r);
            d  = $urandom_range(dmin, dmax);
            for (int k = 0; k <= d; k++) begin
                if (inject) begin
                    in_valid = 1'b1;
                    in       = 32'h0000DEAD;
                    exp_ov   = 1'b1;
                end
                mem_ack = (k == d);
                check("we", mem_we, 1);
                check("rdy_wr", in_ready, 0);
                check("addr", mem_addr, ea);
                check("wdata", mem_wdata, exp_w);
                step();
            end
            mem_ack  = 1'b0;
            in_valid = 1'b0;
            wr_exp++;
            check("we_drop", mem_we, 0);
        end
        check("done", done, 1);
        check("busy_done", busy, 1);
        if (inject) begin
            in_valid = 1'b1;
            in       = 32'h0000DEAD;
        end
        step();
        in_valid = 1'b0;
        check("done_end", done, 0);
        check("busy_end", busy, 0);
        check("ovr", overrun, exp_ov);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        in_valid  = 1'b0;
        in        = '0;
        mem_ack   = 1'b0;
        #1;
        check("rst_rdy", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovr", overrun, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        step();
        reset = 1'b1;
        step();

        run_job(16'h0010, 2, 0, 0, 0, 1'b0, 1'b1);
        idle(3);
        run_job(16'h0100, 1, 1, 5, 5, 1'b0, 1'b0);
        run_job(16'h0200, 2, 1, 0, 2, 1'b1, 1'b0);
        idle(4);
        run_job(16'h0300, 1, 2, 0, 3, 1'b0, 1'b0);
        run_job(16'h0400, 0, 0, 0, 0, 1'b0, 1'b0);
        idle(2);
        run_job(16'hFFFF, 2, 1, 0, 2, 1'b0, 1'b0);

        // Abort a job after three elements of its first row.
        start     = 1'b1;
        base_addr = 16'h0500;
        num_rows  = 8'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in       = $urandom;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        exp_ov = 1'b0;
        check("abort_rdy", in_ready, 0);
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ovr", overrun, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        step();
        reset = 1'b1;
        idle(4);
        run_job(16'h0600, 1, 0, 0, 1, 1'b0, 1'b0);

        for (int j = 0; j < 6; j++) begin
            run_job(16'($urandom), $urandom_range(1, 3), 2, 0, 3, 1'($urandom_range(0, 1)), 1'b0);
            idle($urandom_range(0, 3));
        end

        check("write_count", wr_seen, wr_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
